// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit: saturating-counter table (bimodal or gshare),
// RV32I conditional branch resolution, table training and saturating statistics.
module branch_predict_unit #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GSHARE     = 0,
    parameter int STAT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          if_pc,
    output logic                 pred_taken,
    input  logic                 ex_valid,
    input  logic [1:0]           ex_branch,
    input  logic [2:0]           ex_funct3,
    input  logic [31:0]          ex_rs1,
    input  logic [31:0]          ex_rs2,
    input  logic [31:0]          ex_pc,
    input  logic                 ex_prediction,
    output logic                 taken,
    output logic                 misprediction,
    output logic                 illegal_branch,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] mispredict_count
);

    localparam int                   ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]  CTR_MIN  = {CTR_BITS{1'b0}};
    localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

    logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_cur_s;
    logic [CTR_BITS-1:0]   ctr_upd_d;
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;
    logic [STAT_BITS-1:0]  branch_cnt_q, branch_cnt_d;
    logic [STAT_BITS-1:0]  mispred_cnt_q, mispred_cnt_d;
    logic [INDEX_BITS-1:0] if_idx_s, ex_idx_s;
    logic                  eq_s, lt_s_s, lt_u_s;
    logic                  outcome_s, legal_s, is_cond_s, active_s;
    logic                  unused_pc_bits_s;

    // Both the fetch-side lookup and the EX-side update go through this one mapping.
    function automatic logic [INDEX_BITS-1:0] table_index(
        input logic [INDEX_BITS-1:0] pc_bits,
        input logic [INDEX_BITS-1:0] ghr
    );
        if (GSHARE != 0) begin
            return pc_bits ^ ghr;
        end else begin
            return pc_bits;
        end
    endfunction

    assign if_idx_s = table_index(if_pc[INDEX_BITS+1:2], ghr_q);
    assign ex_idx_s = table_index(ex_pc[INDEX_BITS+1:2], ghr_q);
    assign unused_pc_bits_s = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0],
                                ex_pc[31:INDEX_BITS+2], ex_pc[1:0]};

    // Read-before-write: the lookup sees the table as it stands this cycle.
    assign pred_taken = ctr_q[if_idx_s][CTR_BITS-1];

    assign eq_s   = (ex_rs1 == ex_rs2);
    assign lt_s_s = ($signed(ex_rs1) < $signed(ex_rs2));
    assign lt_u_s = (ex_rs1 < ex_rs2);

    // Decode funct3 into an outcome and a legality flag.
    always_comb begin
        outcome_s = 1'b0;
        legal_s   = 1'b0;
        case (ex_funct3)
            3'b000: begin outcome_s = eq_s;    legal_s = 1'b1; end
            3'b001: begin outcome_s = !eq_s;   legal_s = 1'b1; end
            3'b100: begin outcome_s = lt_s_s;  legal_s = 1'b1; end
            3'b101: begin outcome_s = !lt_s_s; legal_s = 1'b1; end
            3'b110: begin outcome_s = lt_u_s;  legal_s = 1'b1; end
            3'b111: begin outcome_s = !lt_u_s; legal_s = 1'b1; end
            default: begin outcome_s = 1'b0;   legal_s = 1'b0; end
        endcase
    end

    assign is_cond_s      = ex_valid && (ex_branch == 2'b01);
    assign active_s       = is_cond_s && legal_s;
    assign taken          = active_s && outcome_s;
    assign misprediction  = active_s && (outcome_s ^ ex_prediction);
    assign illegal_branch = is_cond_s && !legal_s;

    // Next-state for the trained counter, the history register and the statistics.
    always_comb begin
        ctr_cur_s     = ctr_q[ex_idx_s];
        ctr_upd_d     = ctr_cur_s;
        ghr_d         = ghr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (outcome_s) begin
            if (ctr_cur_s != CTR_MAX) begin
                ctr_upd_d = ctr_cur_s + CTR_BITS'(1);
            end else begin
                ctr_upd_d = ctr_cur_s;
            end
        end else begin
            if (ctr_cur_s != CTR_MIN) begin
                ctr_upd_d = ctr_cur_s - CTR_BITS'(1);
            end else begin
                ctr_upd_d = ctr_cur_s;
            end
        end
        if (active_s) begin
            if (GSHARE != 0) begin
                ghr_d = {ghr_q[INDEX_BITS-2:0], outcome_s};
            end else begin
                ghr_d = ghr_q;
            end
            if (branch_cnt_q != STAT_MAX) begin
                branch_cnt_d = branch_cnt_q + STAT_BITS'(1);
            end else begin
                branch_cnt_d = branch_cnt_q;
            end
            if (misprediction && (mispred_cnt_q != STAT_MAX)) begin
                mispred_cnt_d = mispred_cnt_q + STAT_BITS'(1);
            end else begin
                mispred_cnt_d = mispred_cnt_q;
            end
        end else begin
            ghr_d = ghr_q;
        end
    end

    // State registers; reset discards any update in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (active_s) begin
                ctr_q[ex_idx_s] <= ctr_upd_d;
            end
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: table-driven resolve vectors through a
// scoreboard queue, plus hand sequences for training, collision, gshare and async reset.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, ex_pc, ex_rs1, ex_rs2;
    logic        ex_valid, ex_prediction;
    logic [1:0]  ex_branch;
    logic [2:0]  ex_funct3;
    logic        pred_taken, taken, misprediction, illegal_branch;
    logic [31:0] branch_count, mispredict_count;

    logic [31:0] g_if_pc, g_ex_pc;
    logic        g_valid;
    logic        g_pred_taken, g_taken, g_mis, g_ill;
    logic [31:0] g_branch_count, g_mispredict_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_prediction(ex_prediction),
        .taken(taken), .misprediction(misprediction), .illegal_branch(illegal_branch),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_predict_unit #(.INDEX_BITS(4), .GSHARE(1)) dut_g (
        .clk(clk), .rst(rst), .if_pc(g_if_pc), .pred_taken(g_pred_taken),
        .ex_valid(g_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(g_ex_pc), .ex_prediction(ex_prediction),
        .taken(g_taken), .misprediction(g_mis), .illegal_branch(g_ill),
        .branch_count(g_branch_count), .mispredict_count(g_mispredict_count)
    );

    typedef struct {
        logic [1:0]  br;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pred;
        logic        taken;
        logic        mis;
        logic        ill;
    } vec_t;

    typedef struct {
        logic taken;
        logic mis;
        logic ill;
    } exp_t;

    vec_t vecs[17];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Conditional BEQ whose outcome is forced by the operand values.
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic pred);
        ex_valid      = 1'b1;
        ex_branch     = 2'b01;
        ex_funct3     = 3'b000;
        ex_rs1        = 32'd0;
        ex_rs2        = tk ? 32'd0 : 32'd1;
        ex_pc         = pc;
        ex_prediction = pred;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   exp_bc;
        int   exp_mc;

        vecs[0]  = '{2'b01, 3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 3'b001, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 3'b101, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b01, 3'b111, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 3'b000, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 3'b001, 32'h5, 32'h5, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2'b01, 3'b100, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b01, 3'b101, 32'h5, 32'h5, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{2'b01, 3'b110, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'b01, 3'b111, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{2'b01, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{2'b01, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{2'b01, 3'b010, 32'h5, 32'h5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{2'b01, 3'b011, 32'h5, 32'h5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{2'b10, 3'b000, 32'h5, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; if_pc = 32'h0; ex_pc = 32'h0; ex_rs1 = 32'h0; ex_rs2 = 32'h0;
        ex_valid = 1'b0; ex_prediction = 1'b0; ex_branch = 2'b00; ex_funct3 = 3'b000;
        g_if_pc = 32'h18; g_ex_pc = 32'h0; g_valid = 1'b0;
        #12 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset_pred_0", {31'd0, pred_taken}, 32'd0);
        if_pc = 32'h100; #1;
        check("reset_pred_100", {31'd0, pred_taken}, 32'd0);
        if_pc = 32'hFFFF_FFFC; #1;
        check("reset_pred_top", {31'd0, pred_taken}, 32'd0);
        check("reset_bc", branch_count, 32'd0);
        check("reset_mc", mispredict_count, 32'd0);
        check("reset_gpred", {31'd0, g_pred_taken}, 32'd0);

        // Vector table through the scoreboard.
        exp_bc = 0;
        exp_mc = 0;
        for (int i = 0; i < 17; i++) begin
            next_cycle();
            ex_valid = 1'b1; ex_branch = vecs[i].br; ex_funct3 = vecs[i].f3;
            ex_rs1 = vecs[i].rs1; ex_rs2 = vecs[i].rs2; ex_prediction = vecs[i].pred;
            ex_pc = 32'h400;
            sb_q.push_back('{vecs[i].taken, vecs[i].mis, vecs[i].ill});
            if (vecs[i].br == 2'b01 && !vecs[i].ill) exp_bc++;
            if (vecs[i].mis) exp_mc++;
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("vec%0d_taken", i), {31'd0, taken}, {31'd0, e.taken});
            check($sformatf("vec%0d_mis", i), {31'd0, misprediction}, {31'd0, e.mis});
            check($sformatf("vec%0d_ill", i), {31'd0, illegal_branch}, {31'd0, e.ill});
        end
        next_cycle();
        ex_valid = 1'b0;
        @(negedge clk);
        check("vec_bc", branch_count, 32'(exp_bc));
        check("vec_mc", mispredict_count, 32'(exp_mc));

        next_cycle();
        rst = 1'b1; #2 rst = 1'b0;
        @(negedge clk);
        check("rst2_bc", branch_count, 32'd0);

        // Training: three taken resolves at 0x100, then walk back down.
        next_cycle();
        if_pc = 32'h100;
        for (int k = 0; k < 3; k++) begin
            resolve(32'h100, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("train%0d_pred", k), {31'd0, pred_taken}, (k == 0) ? 32'd0 : 32'd1);
            check($sformatf("train%0d_mis", k), {31'd0, misprediction}, 32'd1);
            next_cycle();
        end
        ex_valid = 1'b0;
        @(negedge clk);
        check("train_pred_sat", {31'd0, pred_taken}, 32'd1);
        check("train_bc", branch_count, 32'd3);
        check("train_mc", mispredict_count, 32'd3);
        next_cycle();
        resolve(32'h100, 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        check("untrain1_pred", {31'd0, pred_taken}, 32'd1);
        next_cycle();
        ex_valid = 1'b0;
        @(negedge clk);
        check("untrain2_pred", {31'd0, pred_taken}, 32'd0);

        // Collision: same entry (now at 1) read and trained in one cycle.
        next_cycle();
        if_pc = 32'h200;
        resolve(32'h200, 1'b1, 1'b0);
        @(negedge clk);
        check("coll_same_cycle", {31'd0, pred_taken}, 32'd0);
        next_cycle();
        ex_valid = 1'b0;
        @(negedge clk);
        check("coll_next_cycle", {31'd0, pred_taken}, 32'd1);

        // Illegal funct3 leaves table and stats alone.
        next_cycle();
        ex_valid = 1'b1; ex_branch = 2'b01; ex_funct3 = 3'b010;
        ex_rs1 = 32'h5; ex_rs2 = 32'h5; ex_pc = 32'h200; ex_prediction = 1'b1;
        @(negedge clk);
        check("ill_flag", {31'd0, illegal_branch}, 32'd1);
        check("ill_taken", {31'd0, taken}, 32'd0);
        check("ill_mis", {31'd0, misprediction}, 32'd0);
        next_cycle();
        ex_valid = 1'b0;
        @(negedge clk);
        check("ill_pred_kept", {31'd0, pred_taken}, 32'd1);
        check("ill_bc", branch_count, 32'd6);
        check("ill_mc", mispredict_count, 32'd4);

        // Asynchronous reset between edges during a resolve stream.
        next_cycle();
        resolve(32'h200, 1'b1, 1'b1);
        next_cycle();
        #1 rst = 1'b1;
        #1;
        check("arst_pred", {31'd0, pred_taken}, 32'd0);
        check("arst_bc", branch_count, 32'd0);
        check("arst_mc", mispredict_count, 32'd0);
        ex_valid = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        check("arst_after_pred", {31'd0, pred_taken}, 32'd0);
        check("arst_after_bc", branch_count, 32'd0);

        // Gshare: taken, taken, not-taken leaves history at 0110.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            resolve(32'h0, (k != 2), 1'b0);
            ex_valid = 1'b0;
            g_valid = 1'b1;
            g_ex_pc = 32'h0;
        end
        next_cycle();
        g_valid = 1'b0;
        @(negedge clk);
        g_if_pc = 32'h18; #1;
        check("gs_pred_18", {31'd0, g_pred_taken}, 32'd1);
        g_if_pc = 32'h1C; #1;
        check("gs_pred_1c", {31'd0, g_pred_taken}, 32'd1);
        g_if_pc = 32'h58; #1;
        check("gs_pred_alias", {31'd0, g_pred_taken}, 32'd1);
        g_if_pc = 32'h00; #1;
        check("gs_pred_00", {31'd0, g_pred_taken}, 32'd0);
        g_if_pc = 32'h04; #1;
        check("gs_pred_04", {31'd0, g_pred_taken}, 32'd0);
        check("gs_bc", g_branch_count, 32'd3);
        check("gs_mc", g_mispredict_count, 32'd2);

        // History must also clear on reset.
        next_cycle();
        rst = 1'b1; #2 rst = 1'b0;
        g_if_pc = 32'h18; #1;
        check("gs_rst_pred", {31'd0, g_pred_taken}, 32'd0);
        next_cycle();
        resolve(32'h0, 1'b1, 1'b0);
        ex_valid = 1'b0;
        g_valid = 1'b1;
        g_ex_pc = 32'h0;
        next_cycle();
        g_valid = 1'b0;
        g_if_pc = 32'h04;
        @(negedge clk);
        check("gs_rst_ghr", {31'd0, g_pred_taken}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch prediction and resolution unit for the RV32I pipeline. Predicts conditional branches in IF from a table of saturating counters, indexed bimodally or gshare-style. Resolves the real outcome in EX from both source operands for all six RV32I conditional branch types. Flags mispredictions, trains the table, and keeps saturating performance counters.

## Interface
Parameters:
- INDEX_BITS, 6, table holds 2^INDEX_BITS counters
- CTR_BITS, 2, width of each saturating counter (2..4)
- GSHARE, 0, 0 = bimodal index; 1 = index XORed with the global history register (GHR)
- STAT_BITS, 32, width of the statistics counters

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  32  PC of the instruction being fetched
- pred_taken  out  1  prediction for if_pc (combinational)
- ex_valid  in  1  EX holds a valid instruction
- ex_branch  in  2  branch class; 2'b01 = conditional branch, anything else is ignored
- ex_funct3  in  3  branch funct3
- ex_rs1, ex_rs2  in  32  source operand values
- ex_pc  in  32  PC of the EX instruction
- ex_prediction  in  1  prediction carried down the pipe with the instruction
- taken  out  1  resolved outcome (combinational)
- misprediction  out  1  taken XOR ex_prediction for an active resolve (combinational)
- illegal_branch  out  1  conditional branch with funct3 010 or 011 (combinational)
- branch_count  out  STAT_BITS  number of resolved branches
- mispredict_count  out  STAT_BITS  number of mispredictions

## Operation
- **Active resolve:** ex_valid & ex_branch==2'b01 & funct3 is legal.
- **Outcome, by funct3:**
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed rs1<rs2
  - 101 BGE: signed rs1>=rs2
  - 110 BLTU: unsigned rs1<rs2
  - 111 BGEU: unsigned rs1>=rs2
- **Outputs when not active:** taken=0 and misprediction=0. illegal_branch=1 only for ex_valid & ex_branch==01 & funct3 in {010,011}. An illegal branch causes no training and no counting.
- **Index:**
  - Bimodal: pc[INDEX_BITS+1:2].
  - GSHARE=1: pc[INDEX_BITS+1:2] XOR ghr. The ghr is INDEX_BITS wide.
  - The same function is applied to if_pc for prediction and to ex_pc for training.
- **Prediction:** pred_taken = MSB of the counter selected by if_pc.
- **Training, on an active resolve at the clock edge:**
  - Counter increments if taken, decrements if not.
  - It saturates at 2^CTR_BITS-1 and at 0.
- **GHR (GSHARE=1 only):** on an active resolve, ghr <= {ghr[INDEX_BITS-2:0], taken}. It is updated non-speculatively and only in EX.
- **Statistics:**
  - branch_count increments on every active resolve.
  - mispredict_count increments on active resolves with misprediction=1.
  - Both hold at all-ones (saturate) and never wrap.
- **Reset values:**
  - Every counter = 2^(CTR_BITS-1)-1 (weakly not-taken), so pred_taken=0 after reset.
  - ghr=0, branch_count=0, mispredict_count=0.
- **Reset mid-operation:** asynchronous. It clears all state immediately, regardless of clk. Any in-flight update is discarded.

## Timing
- Prediction is combinational on if_pc, with zero latency.
- taken, misprediction and illegal_branch are combinational on the EX inputs, with zero latency.
- Table, ghr and stats update on the rising edge that ends the resolve cycle. The new values are visible in the following cycle.
- **Same-index collision:** if if_pc and ex_pc select the same entry in one cycle, pred_taken uses the pre-update value (read-before-write). There is no bypass.
- **Multiple resolves:** back-to-back resolves to one entry each apply exactly one step per cycle.
- **Index width:** the PC is truncated above bit INDEX_BITS+1. Aliasing between PCs that differ only in upper bits is expected and allowed.
- Signed comparison uses two's complement on the full 32 bits. 0x80000000 is the most negative value.

## Test plan
- **Reset:**
  - Assert rst, then release.
  - Required: pred_taken=0 for any if_pc; branch_count=0; mispredict_count=0; ghr=0.
- **Branch types:**
  - rs1=0xFFFFFFFF, rs2=0x00000001 with each funct3.
  - Required taken: BEQ 0, BNE 1, BLT 1, BGE 0, BLTU 0, BGEU 1.
  - Repeat with rs1=rs2=5.
- **Training (bimodal, CTR_BITS=2):**
  - Apply three taken resolves at ex_pc=0x100, each with ex_prediction=0.
  - Required:
    - pred_taken for if_pc=0x100 becomes 1 after the first edge.
    - The counter saturates at 3.
    - Mispredictions counted = 3.
    - branch_count = 3.
- **Collision:**
  - With if_pc=ex_pc=0x200, entry at 1, resolve taken.
  - Required: pred_taken=0 in that cycle and 1 in the next.
- **GSHARE=1, INDEX_BITS=4:**
  - Resolve taken, taken, not-taken.
  - Required: ghr=4'b0110, and prediction indexes into pc-index^0110.
- **Illegal funct3 and reset mid-operation:**
  - funct3=010 with ex_branch=01.
    - Required: illegal_branch=1, taken=0, no change to counters.
  - Assert rst asynchronously between edges during a resolve stream.
    - Required: all state returns to reset values before the next edge.
